seg_display_scan: RTL and testbench

- Parametrised multiplexed seven-segment display controller for the CPU top level. It replaces the fixed 4-digit, hex-only driver logic.
- Accepts a value over a valid/ready load port and converts it to hex or decimal. Decimal uses a sequential double-dabble conversion.
- Commits converted digits atomically and time-multiplexes them onto shared segment lines, with optional leading-zero blanking and overflow indication.

---
 rtl/seg_display_scan.sv | 167 ++++++++++++++++
 tb/tb_seg_display_scan.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment controller: accepts a value, converts it to hex or
// decimal (sequential double-dabble), commits digits atomically and scans them out.
module seg_display_scan #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_dec,
  input  logic              blank_lz,
  output logic              busy,
  output logic [7:0]        segments,
  output logic [DIGITS-1:0] an
);
  localparam int BW = 4*DIGITS + 4;
  localparam int HW = (DATA_W > 4*DIGITS) ? DATA_W : 4*DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, HEX, DEC, COMMIT} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    dec_q, dec_d, pend_blank_q, pend_blank_d;
  logic [BW-1:0]           bcd_q, bcd_d, bcd_adj;
  logic                    sticky_q, sticky_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]  dig_q, dig_d;
  logic                    ovf_q, ovf_d, blank_q, blank_d;
  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic [HW-1:0]           hex_ext;
  logic                    hex_ovf;
  logic [DIGITS-1:0]       lz;
  logic                    nz;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign segments   = seg_q;
  assign an         = an_q;

  assign hex_ext = HW'(data_q);
  assign hex_ovf = (hex_ext >> (4*DIGITS)) != '0;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i <= DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    dec_d        = dec_q;
    pend_blank_d = pend_blank_q;
    bcd_d        = bcd_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    ovf_d        = ovf_q;
    blank_d      = blank_q;
    case (state_q)
      IDLE: if (load_valid) begin
        data_d       = load_data;
        dec_d        = load_dec;
        pend_blank_d = blank_lz;
        bcd_d        = '0;
        sticky_d     = 1'b0;
        cnt_d        = '0;
        state_d      = load_dec ? DEC : HEX;
      end
      HEX: state_d = COMMIT;
      DEC: begin
        // a bit leaving the top nibble means the value is far past 10^DIGITS
        bcd_d    = {bcd_adj[BW-2:0], data_q[DATA_W-1]};
        sticky_d = sticky_q | bcd_adj[BW-1];
        data_d   = data_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = COMMIT;
      end
      default: begin
        state_d = IDLE;
        blank_d = pend_blank_q;
        if (dec_q) begin
          for (int i = 0; i < DIGITS; i++) dig_d[i] = bcd_q[4*i +: 4];
          ovf_d = sticky_q | (bcd_q[BW-1 -: 4] != 4'd0);
        end else begin
          for (int i = 0; i < DIGITS; i++) dig_d[i] = hex_ext[4*i +: 4];
          ovf_d = hex_ovf;
        end
      end
    endcase
  end

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // leading-zero mask: a digit blanks when it and everything above it are zero
  always_comb begin
    nz = 1'b0;
    lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz    = nz | (dig_q[i] != 4'd0);
      lz[i] = blank_q & ~nz & (i != 0);
    end
    an_d = ~(DIGITS'(1) << idx_q);
    if (ovf_q)           seg_d = 8'hBF;
    else if (lz[idx_q])  seg_d = 8'hFF;
    else                 seg_d = glyph(dig_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      dec_q        <= 1'b0;
      pend_blank_q <= 1'b0;
      bcd_q        <= '0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      dig_q        <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      div_q        <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      dec_q        <= dec_d;
      pend_blank_q <= pend_blank_d;
      bcd_q        <= bcd_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      ovf_q        <= ovf_d;
      blank_q      <= blank_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: cycle-by-cycle reference model plus literal digit checks.
module tb_seg_display_scan;
  localparam int D = 4, W = 16, WB = 20, RD = 4;

  logic clk = 0, rst = 1;
  logic lv = 0, ld_dec = 0, blz = 0;
  logic [W-1:0] ld = '0;
  logic ready, busy;
  logic [7:0] seg;
  logic [D-1:0] an;
  logic blv = 0, bdec = 0, bblz = 0;
  logic [WB-1:0] bld = '0;
  logic b_ready, b_busy;
  logic [7:0] b_seg;
  logic [D-1:0] b_an;

  seg_display_scan #(.DIGITS(D), .DATA_W(W), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready), .load_data(ld),
    .load_dec(ld_dec), .blank_lz(blz), .busy(busy), .segments(seg), .an(an));

  seg_display_scan #(.DIGITS(D), .DATA_W(WB), .REFRESH_DIV(RD)) dut_b (
    .clk(clk), .rst(rst), .load_valid(blv), .load_ready(b_ready), .load_data(bld),
    .load_dec(bdec), .blank_lz(bblz), .busy(b_busy), .segments(b_seg), .an(b_an));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [7:0] gly [16];
  initial gly = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_left, m_tick, m_idx;
  int m_dig [D];
  int p_dig [D];
  bit m_ovf, m_blank, p_ovf, p_blank, m_on = 0;
  logic [D-1:0] e_an;
  logic [7:0] e_seg;

  function automatic logic [7:0] shown(input int i);
    int msd;
    msd = 0;
    for (int j = 0; j < D; j++) if (m_dig[j] != 0) msd = j;
    if (m_ovf) return 8'hBF;
    if (m_blank && i > msd) return 8'hFF;
    return gly[m_dig[i]];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_tick = 0; m_ovf = 0; m_blank = 0;
      for (int i = 0; i < D; i++) m_dig[i] = 0;
      e_an = '1; e_seg = 8'hFF;
    end else begin
      m_idx = (m_tick / RD) % D;
      e_an  = ~(D'(1) << m_idx);
      e_seg = shown(m_idx);
      m_tick++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < D; i++) m_dig[i] = p_dig[i];
          m_ovf = p_ovf; m_blank = p_blank;
        end
      end else if (lv) begin
        int v, p;
        v = int'(ld); p = 1;
        for (int i = 0; i < D; i++) begin
          p_dig[i] = ld_dec ? (v / p) % 10 : (v >> (4*i)) & 15;
          p = p * 10;
        end
        p_ovf   = ld_dec ? (v >= p) : ((v >> (4*D)) != 0);
        p_blank = blz;
        m_left  = ld_dec ? W + 1 : 2;
      end
    end
  end

  always @(negedge clk) if (m_on) begin
    chk("an", an, e_an);
    chk("segments", seg, e_seg);
    chk("busy", busy, m_left > 0);
    chk("load_ready", ready, m_left == 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input int which, input logic [31:0] v, input bit dec, input bit bz);
    @(negedge clk); #1;
    if (which == 0) begin lv = 1; ld = v[W-1:0]; ld_dec = dec; blz = bz; end
    else begin blv = 1; bld = v[WB-1:0]; bdec = dec; bblz = bz; end
    @(negedge clk); #1;
    lv = 0; blv = 0;
  endtask

  task automatic busy_len(input int which, input int exp, input string nm);
    int n;
    n = 0;
    while ((which == 0 ? busy : b_busy) === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  task automatic see_digit(input int which, input int i, input logic [7:0] exp, input string nm);
    int n;
    logic [D-1:0] want;
    want = ~(D'(1) << i);
    n = 0;
    @(negedge clk);
    while ((which == 0 ? an : b_an) !== want && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL %s: digit %0d never selected", nm, i);
    end else chk(nm, which == 0 ? seg : b_seg, exp);
  endtask

  task automatic see_all(input int which, input logic [31:0] exp4, input string nm);
    logic [31:0] e;
    e = exp4;
    for (int i = 0; i < D; i++) see_digit(which, i, e[8*i +: 8], nm);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2 rst = 0;
    m_on = 1;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("scan_first_an", an, 4'hE);
    chk("scan_first_seg", seg, 8'hC0);
    repeat (4) @(negedge clk);
    chk("scan_second_an", an, 4'hD);
    repeat (12) @(negedge clk);
    chk("scan_wrap_an", an, 4'hE);

    do_load(0, 32'h1A2F, 0, 0);
    busy_len(0, 2, "hex_busy_len");
    see_all(0, 32'hF9_88_A4_8E, "hex_1A2F");

    do_load(0, 1234, 1, 0);
    busy_len(0, 17, "dec_busy_len");
    see_all(0, 32'hF9_A4_B0_99, "dec_1234");

    do_load(0, 42, 1, 1);
    busy_len(0, 17, "dec42_busy");
    see_all(0, 32'hFF_FF_99_A4, "dec_42_blank");

    do_load(0, 0, 1, 1);
    busy_len(0, 17, "dec0_busy");
    see_all(0, 32'hFF_FF_FF_C0, "dec_0_blank");

    do_load(0, 10000, 1, 1);
    busy_len(0, 17, "dec_ovf_busy");
    see_all(0, 32'hBF_BF_BF_BF, "dec_10000_ovf");

    // valid held through the whole conversion with a different value
    @(negedge clk); #1;
    lv = 1; ld = 16'd9999; ld_dec = 1; blz = 0;
    @(negedge clk); #1;
    ld = 16'd5;
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
      #1 lv = 0;
      chk("held_valid_busy_len", n, 17);
    end
    see_all(0, 32'h90_90_90_90, "held_valid_9999");

    // reset in the middle of a conversion discards it
    do_load(0, 4321, 1, 0);
    repeat (5) @(negedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_an", an, 4'hF);
    repeat (2) @(negedge clk);
    #1 rst = 1;
    repeat (30) @(negedge clk);
    chk("midrst_no_commit_busy", busy, 0);
    see_all(0, 32'hC0_C0_C0_C0, "midrst_zero");

    // wider data port: hex overflow and hex blanking
    do_load(1, 32'h10000, 0, 0);
    busy_len(1, 2, "b_hex_busy");
    see_all(1, 32'hBF_BF_BF_BF, "b_hex_ovf");
    do_load(1, 32'h0F00A, 0, 1);
    busy_len(1, 2, "b_hex_busy2");
    see_all(1, 32'h8E_C0_C0_88, "b_hex_0F00A");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
